// File: rtl/tb_request_scheduler_if.sv
// Button/request bundle between the tail-light front end and its environment.
//   slave  : scheduler side (buttons in, step/requests/grant out)
//   master : environment side (drives buttons, observes outputs)
//   left/right/haz        raw active-low buttons
//   step                  one-cycle sequencer advance enable
//   *_req_n               granted request, active low (at most one low)
//   grant                 00 none, 01 left, 10 right, 11 hazard
//   busy                  grant != 00
interface tb_request_scheduler_if;
  logic       left, right, haz;
  logic       step;
  logic       left_req_n, right_req_n, haz_req_n;
  logic [1:0] grant;
  logic       busy;

  modport slave (
    input  left, right, haz,
    output step, left_req_n, right_req_n, haz_req_n, grant, busy
  );
  modport master (
    output left, right, haz,
    input  step, left_req_n, right_req_n, haz_req_n, grant, busy
  );
endinterface

// File: rtl/tb_request_scheduler.sv
// Front-end controller for the Thunderbird tail-light sequencer.
// Synchronises the raw active-low buttons, latches presses as sticky pending
// requests, arbitrates hazard > left > right and holds one grant on the
// sequencer's active-low request lines for a fixed number of step pulses.
// A free-running prescaler produces the one-cycle step enable.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    tb_request_scheduler_if.slave (buttons in, step/req_n/grant/busy out)
// Configuration:
//   TB_SCHED_AUTO_REPEAT_EN  when defined, a grant whose count expires while
//   the same button is still held (and no hazard is pending) reloads and keeps
//   its request asserted without passing through IDLE.
module tb_request_scheduler #(
  parameter int DIV_WIDTH   = 26,
  parameter int SYNC_STAGES = 2,
  parameter int LR_STEPS    = 4,
  parameter int HAZ_STEPS   = 2
) (
  input logic               clk,
  input logic               reset,
  tb_request_scheduler_if.slave bus
);
  localparam int MAXS = (LR_STEPS > HAZ_STEPS) ? LR_STEPS : HAZ_STEPS;
  localparam int CW   = $clog2(MAXS + 1);
  localparam int BL = 0, BR = 1, BH = 2;   // button index in the 3-bit vectors

  // State encoding equals the grant code so grant is the state register itself.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_L   = 2'b01,
    GNT_R   = 2'b10,
    GNT_HAZ = 2'b11
  } state_t;

  // ---------------- prescaler ----------------
  logic [DIV_WIDTH-1:0] div_q;
  logic                 step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else begin
      div_q  <= div_q + 1'b1;
      step_q <= &div_q;
    end
  end

  // ---------------- synchronisers ----------------
  logic [2:0]                  raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  s_low;

  assign raw = {bus.haz, bus.right, bus.left};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      for (int b = 0; b < 3; b++)
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
    end
  end

  always_comb begin
    s_low = '0;
    for (int b = 0; b < 3; b++) s_low[b] = ~sync_q[b][SYNC_STAGES-1];
  end

  // ---------------- arbiter / grant FSM ----------------
  state_t        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    req_n_q;     // {haz, right, left}
  logic          busy_q;
  logic [1:0]    own;         // button index of the current left/right grant

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pend_d = pend_q | s_low;
    own    = (st_q == GNT_R) ? 2'(BR) : 2'(BL);
    case (st_q)
      IDLE: begin
        if (pend_q[BH]) begin
          st_d = GNT_HAZ; cnt_d = CW'(HAZ_STEPS); pend_d[BH] = 1'b0;
        end else if (pend_q[BL]) begin
          st_d = GNT_L;   cnt_d = CW'(LR_STEPS);  pend_d[BL] = 1'b0;
        end else if (pend_q[BR]) begin
          st_d = GNT_R;   cnt_d = CW'(LR_STEPS);  pend_d[BR] = 1'b0;
        end
      end
      GNT_L, GNT_R: begin
        pend_d[own] = 1'b0;               // re-press of the granted button is dropped
        if (pend_q[BH]) begin             // hazard pre-empts; the L/R grant is abandoned
          st_d = GNT_HAZ; cnt_d = CW'(HAZ_STEPS); pend_d[BH] = 1'b0;
        end else if (step_q) begin
          if (cnt_q == CW'(1)) begin
`ifdef TB_SCHED_AUTO_REPEAT_EN
            if (s_low[own]) begin
              cnt_d = CW'(LR_STEPS);
            end else begin
              st_d = IDLE; cnt_d = '0;
            end
`else
            st_d = IDLE; cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      GNT_HAZ: begin
        pend_d[BH] = 1'b0;
        if (step_q) begin
          if (cnt_q == CW'(1)) begin
`ifdef TB_SCHED_AUTO_REPEAT_EN
            if (s_low[BH]) begin
              cnt_d = CW'(HAZ_STEPS);
            end else begin
              st_d = IDLE; cnt_d = '0;
            end
`else
            st_d = IDLE; cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      req_n_q <= 3'b111;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_n_q <= {st_d != GNT_HAZ, st_d != GNT_R, st_d != GNT_L};
      busy_q  <= (st_d != IDLE);
    end
  end

  assign bus.step        = step_q;
  assign bus.left_req_n  = req_n_q[BL];
  assign bus.right_req_n = req_n_q[BR];
  assign bus.haz_req_n   = req_n_q[BH];
  assign bus.grant       = st_q;
  assign bus.busy        = busy_q;
endmodule
